// File: rtl/seg_pair_decoder.sv
// Two-digit seven-segment frame decoder with stability filter; publishes 0..15.
// Optional err pulse on rejected frames when SEG_PAIR_DECODER_ERR_EN is defined.
module seg_pair_decoder #(
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       digit_sel,
  input  logic       seg_valid,
  output logic [3:0] d_out,
  output logic       d_valid,
  output logic       err
);

  localparam logic [1:0] S_LO   = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;

  localparam logic [3:0] LP_SF = 4'(STABLE_FRAMES);

  logic [1:0] r_state;
  logic [6:0] r_lo_pat;
  logic [6:0] r_hi_pat;
  logic [3:0] r_cnt;
  logic [3:0] r_cand;
  logic [3:0] r_d_out;
  logic       r_d_valid;

  logic       w_lo_ok;
  logic [3:0] w_lo_val;
  logic       w_hi_ok;
  logic       w_hi_val;
  logic [4:0] w_frame;
  logic       w_frame_ok;
  logic [3:0] w_cnt_next;
  logic [3:0] w_cand_next;
  logic       w_publish;

  always_comb begin
    w_lo_ok  = 1'b1;
    w_lo_val = 4'd0;
    case (r_lo_pat)
      7'b1000000: w_lo_val = 4'd0;
      7'b1111001: w_lo_val = 4'd1;
      7'b0100100: w_lo_val = 4'd2;
      7'b0110000: w_lo_val = 4'd3;
      7'b0011001: w_lo_val = 4'd4;
      7'b0010010: w_lo_val = 4'd5;
      7'b0000010: w_lo_val = 4'd6;
      7'b1111000: w_lo_val = 4'd7;
      7'b0000000: w_lo_val = 4'd8;
      7'b0010000: w_lo_val = 4'd9;
      default:    w_lo_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_hi_ok  = 1'b1;
    w_hi_val = 1'b0;
    case (r_hi_pat)
      7'b1000000: w_hi_val = 1'b0;
      7'b1111001: w_hi_val = 1'b1;
      default:    w_hi_ok  = 1'b0;
    endcase
  end

  // Candidate/counter update as seen at the end of S_EVAL; publish decision uses the updated values.
  always_comb begin
    w_frame     = (w_hi_val ? 5'd10 : 5'd0) + {1'b0, w_lo_val};
    w_frame_ok  = w_lo_ok && w_hi_ok && (w_frame <= 5'd15);
    w_cnt_next  = r_cnt;
    w_cand_next = r_cand;
    if (w_frame_ok) begin
      if (w_frame[3:0] == r_cand) begin
        if (r_cnt < LP_SF) w_cnt_next = r_cnt + 4'd1;
      end else begin
        w_cand_next = w_frame[3:0];
        w_cnt_next  = 4'd1;
      end
    end else begin
      w_cnt_next = '0;
    end
    w_publish = w_frame_ok && (w_cnt_next == LP_SF) && (w_cand_next != r_d_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_LO;
      r_lo_pat  <= '1;
      r_hi_pat  <= '1;
      r_cnt     <= '0;
      r_cand    <= '0;
      r_d_out   <= '0;
      r_d_valid <= 1'b0;
    end else begin
      r_d_valid <= 1'b0;
      case (r_state)
        S_LO: begin
          if (seg_valid && !digit_sel) begin
            r_lo_pat <= seg_in;
            r_state  <= S_HI;
          end
        end
        S_HI: begin
          if (seg_valid) begin
            if (digit_sel) begin
              r_hi_pat <= seg_in;
              r_state  <= S_EVAL;
            end else begin
              r_lo_pat <= seg_in;
            end
          end
        end
        S_EVAL: begin
          r_state <= S_LO;
          r_cnt   <= w_cnt_next;
          r_cand  <= w_cand_next;
          if (w_publish) begin
            r_d_out   <= w_cand_next;
            r_d_valid <= 1'b1;
          end
        end
        default: r_state <= S_LO;
      endcase
    end
  end

`ifdef SEG_PAIR_DECODER_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_EVAL) && !w_frame_ok;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign d_out   = r_d_out;
  assign d_valid = r_d_valid;

endmodule

// File: doc/seg_pair_decoder.md
SEG_PAIR_DECODER -- requirements
Module: seg_pair_decoder

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 2, meaning the number of consecutive identical valid frames required before publishing a value (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port seg_in, input, 7, active-low segment pattern {g,f,e,d,c,b,a}.
REQ-005 SHALL have port digit_sel, input, 1, digit qualifier: 0 = low (units) digit, 1 = high (tens) digit.
REQ-006 SHALL have port seg_valid, input, 1, a one-cycle strobe meaning seg_in/digit_sel are sampled this cycle.
REQ-007 SHALL have port d_out, output, 4, the last published value 0..15.
REQ-008 SHALL have port d_valid, output, 1, a one-cycle pulse when d_out updates.
REQ-009 SHALL have port err, output, 1, a one-cycle pulse on a rejected frame (see Configuration).

Function
REQ-010 SHALL decode low-digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other pattern is invalid.
REQ-011 SHALL accept only 1000000 (0) or 1111001 (1) as a high digit; any other pattern is invalid.
REQ-012 SHALL implement FSM S_LO -> S_HI -> S_EVAL -> S_LO, with reset state S_LO.
REQ-013 In S_LO, a seg_valid with digit_sel=0 SHALL latch the low pattern and move to S_HI; seg_valid with digit_sel=1 SHALL be ignored (resynchronisation).
REQ-014 In S_HI, seg_valid with digit_sel=1 SHALL latch the high pattern and move to S_EVAL; seg_valid with digit_sel=0 SHALL overwrite the latched low pattern and stay in S_HI.
REQ-015 S_EVAL SHALL last exactly one cycle; seg_valid arriving during S_EVAL SHALL be dropped.
REQ-016 In S_EVAL the frame value SHALL be hi*10+lo as a 5-bit intermediate; the frame is valid only if both digits decode and the value is <=15.
REQ-017 On a valid frame equal to the held candidate, a 4-bit match counter SHALL increment, saturating at STABLE_FRAMES; otherwise the candidate SHALL load the value and the counter SHALL be set to 1.
REQ-018 When the counter equals STABLE_FRAMES after the S_EVAL update and the candidate differs from d_out, the block SHALL register d_out=candidate and pulse d_valid in the cycle after S_EVAL.
REQ-019 Repeated stable frames equal to d_out SHALL NOT pulse d_valid.
REQ-020 An invalid frame SHALL clear the counter to 0, leave the candidate and d_out unchanged, and be handled per REQ-026/027.
REQ-021 Latency SHALL be one clk from the high-digit seg_valid to the d_valid/err pulse.

Reset
REQ-022 Asserting rst at any time SHALL force state=S_LO, d_out=0, d_valid=0, err=0, counter=0, candidate=0, and latched patterns=1111111.
REQ-023 A frame in progress at reset SHALL be discarded with no pulse issued.
REQ-024 On release of rst, the first seg_valid SHALL be processed in the first rising edge after deassertion.

Configuration
REQ-025 The macro SEG_PAIR_DECODER_ERR_EN SHALL control error reporting.
REQ-026 With SEG_PAIR_DECODER_ERR_EN defined, an invalid frame SHALL pulse err for one cycle, aligned as d_valid would be.
REQ-027 Without the macro, err SHALL be tied to 0; invalid frames SHALL still clear the counter silently.

Verification
REQ-028 With STABLE_FRAMES=2, send frames lo=1000000/hi=1111001 twice -> exactly one d_valid, d_out=10, err=0.
REQ-029 Send a single frame lo=0010000/hi=1000000 followed by lo=0011001/hi=1000000, twice -> d_valid only after the second 4 frame, d_out=4; 9 never published.
REQ-030 Send frame lo=0110000/hi=1111001 (value 13) twice, then hi=1111001/lo=0000000 (18) with ERR_EN -> d_out=13, then err pulse, d_out stays 13.
REQ-031 Send lo=0100100, rst asserted mid-frame, then hi=1111001 -> no pulse; d_out=0; FSM back in S_LO and the hi strobe is ignored.
REQ-032 Send three stable frames of value 7, then two more of 7 -> exactly one d_valid total.
REQ-033 Send seg_valid in S_EVAL and hi strobes in S_LO -> strobes dropped/ignored; a subsequent clean frame pair is decoded correctly.
